// File: rtl/palette_lut.sv
// Programmable colour palette (flop storage, async-reset defaults) with per-request brightness scaling.
// Result 2 cycles after acceptance; a held output freezes both stages and drops in_ready.
module palette_lut #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  colour,
  input  logic [CH_W-1:0]   bright,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3*CH_W-1:0] rgb,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int RGB_W = 3 * CH_W;
  localparam int PW    = 2 * CH_W + 1;

  // Entries above 7 repeat the 8-colour pattern; narrow indices zero-fill.
  function automatic logic [RGB_W-1:0] default_entry(input int i);
    logic [2:0] b;
    b = i[2:0];
    return {{CH_W{b[2]}}, {CH_W{b[1]}}, {CH_W{b[0]}}};
  endfunction

  logic [RGB_W-1:0] pal [DEPTH];
  logic [RGB_W-1:0] s1_data;
  logic [RGB_W-1:0] scaled;
  logic [CH_W-1:0]  s1_bright;
  logic             s1_valid;
  logic             stall;
  logic             accept;
  logic [CH_W:0]    gain;
  logic [CH_W-1:0]  ch;
  logic [PW-1:0]    prod;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pal[i] <= default_entry(i);
    end else if (wr_en) begin
      pal[wr_idx] <= wr_rgb;
    end
  end

  // The lookup reads pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_bright <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_data   <= pal[colour];
        s1_bright <= bright;
      end
    end
  end

  always_comb begin
    scaled = '0;
    ch     = '0;
    prod   = '0;
    gain   = {1'b0, s1_bright} + (CH_W+1)'(1);
    for (int c = 0; c < 3; c++) begin
      ch   = s1_data[c*CH_W +: CH_W];
      prod = PW'(ch) * PW'(gain);
      scaled[c*CH_W +: CH_W] = CH_W'(prod >> CH_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rgb       <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) rgb <= scaled;
    end
  end
endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: default and narrow/wide parameter instances.
module tb_palette_lut;
  localparam int IW = 3, CW = 8, RW = 24;
  localparam int IW2 = 4, CW2 = 4, RW2 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          in_valid, in_ready, out_valid, out_ready, wr_en;
  logic [IW-1:0] colour, wr_idx;
  logic [CW-1:0] bright;
  logic [RW-1:0] rgb, wr_rgb;

  logic           in_valid2, in_ready2, out_valid2, out_ready2, wr_en2;
  logic [IW2-1:0] colour2, wr_idx2;
  logic [CW2-1:0] bright2;
  logic [RW2-1:0] rgb2, wr_rgb2;

  palette_lut #(.IDX_W(IW), .CH_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .colour(colour), .bright(bright), .out_valid(out_valid), .out_ready(out_ready),
    .rgb(rgb), .wr_en(wr_en), .wr_idx(wr_idx), .wr_rgb(wr_rgb));

  palette_lut #(.IDX_W(IW2), .CH_W(CW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .colour(colour2), .bright(bright2), .out_valid(out_valid2), .out_ready(out_ready2),
    .rgb(rgb2), .wr_en(wr_en2), .wr_idx(wr_idx2), .wr_rgb(wr_rgb2));

  int errors = 0, checks = 0;
  logic [RW-1:0]  q[$];
  logic [RW2-1:0] q2[$];
  logic [RW-1:0]  model[8];
  logic           last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] model_default(input int i);
    int r, g, b;
    r = ((i / 4) % 2 == 1) ? 255 : 0;
    g = ((i / 2) % 2 == 1) ? 255 : 0;
    b = (i % 2 == 1) ? 255 : 0;
    return RW'(r * 65536 + g * 256 + b);
  endfunction

  // Each channel multiplied by (bright+1)/256, rounded down.
  function automatic logic [RW-1:0] model_scale(input logic [RW-1:0] e, input int br);
    int r, g, b;
    r = int'(e[23:16]) * (br + 1) / 256;
    g = int'(e[15:8])  * (br + 1) / 256;
    b = int'(e[7:0])   * (br + 1) / 256;
    return RW'(r * 65536 + g * 256 + b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = model_default(i);
  endtask

  task automatic drive(input logic v, input int c, input int b, input logic ordy,
                       input logic we, input int wi, input logic [RW-1:0] wd);
    @(negedge clk);
    in_valid = v; colour = IW'(c); bright = CW'(b); out_ready = ordy;
    wr_en = we; wr_idx = IW'(wi); wr_rgb = wd;
    #1;
    last_acc = v && in_ready;
    if (last_acc) q.push_back(model_scale(model[c], b));
    if (we) model[wi] = wd;
  endtask

  task automatic drive2(input logic v, input int c, input int b, input logic we,
                        input int wi, input logic [RW2-1:0] wd, input logic [RW2-1:0] exp);
    @(negedge clk);
    in_valid2 = v; colour2 = IW2'(c); bright2 = CW2'(b); out_ready2 = 1'b1;
    wr_en2 = we; wr_idx2 = IW2'(wi); wr_rgb2 = wd;
    #1;
    if (v && in_ready2) q2.push_back(exp);
  endtask

  initial begin
    forever begin
      @(negedge clk); #2;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rgb_unexpected: got %h expected none", rgb);
        end else check("rgb", 32'(rgb), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #2;
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL rgb2_unexpected: got %h expected none", rgb2);
        end else check("rgb2", 32'(rgb2), 32'(q2.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         have_req;
    int           rc, rb;
    logic [31:0]  seen;
    rst_n = 1'b0;
    in_valid = 0; colour = 0; bright = 0; out_ready = 1; wr_en = 0; wr_idx = 0; wr_rgb = 0;
    in_valid2 = 0; colour2 = 0; bright2 = 0; out_ready2 = 1; wr_en2 = 0; wr_idx2 = 0; wr_rgb2 = 0;
    model_reset();
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_rgb", 32'(rgb), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    #12 rst_n = 1'b1;

    // Default palette, unity gain, back-to-back, with latency check
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 255, 1, 0, 0, 0);
      if (i == 1) check("latency_not_yet", 32'(out_valid), 0);
      if (i == 2) check("latency_valid", 32'(out_valid), 1);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);

    // Scaling
    drive(1, 7, 'h7F, 1, 0, 0, 0);
    drive(1, 4, 'h00, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 2, 24'h8040FF);
    drive(1, 2, 'h3F, 1, 0, 0, 0);
    drive(1, 2, 'hFF, 1, 0, 0, 0);

    // Same-edge write/read returns old contents, next request sees new
    drive(1, 5, 255, 1, 1, 5, 24'h123456);
    drive(1, 5, 255, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);

    // Backpressure
    drive(1, 1, 255, 1, 0, 0, 0);
    drive(1, 2, 255, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 255, 0, 0, 0, 0);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_rgb_hold", 32'(rgb), 32'h0000FF);
    end
    seen = 0;
    do begin
      drive(1, 3, 255, 1, 0, 0, 0);
      seen++;
    end while (!last_acc && seen < 10);
    check("stall_release_accept", 32'(last_acc), 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, 0);

    // Reset with two results in flight after a write to entry 0
    drive(0, 0, 0, 1, 1, 0, 24'hABCDEF);
    drive(1, 0, 255, 0, 0, 0, 0);
    drive(1, 0, 255, 0, 0, 0, 0);
    @(negedge clk); #3;
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 0);
    q.delete();
    model_reset();
    @(negedge clk); #1 rst_n = 1'b1;
    drive(1, 0, 255, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);

    // Randomised traffic with interleaved writes and backpressure
    have_req = 0; rc = 0; rb = 0;
    for (int n = 0; n < 400; n++) begin
      if (!have_req && $urandom_range(0, 9) < 7) begin
        have_req = 1;
        rc = $urandom_range(0, 7);
        case ($urandom_range(0, 3))
          0: rb = 0;
          1: rb = 255;
          default: rb = $urandom_range(0, 255);
        endcase
      end
      drive(have_req, rc, rb, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7), RW'($urandom));
      if (last_acc) have_req = 0;
    end
    seen = 0;
    while (q.size() != 0 && seen < 20) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      seen++;
    end
    check("drain_empty", 32'(q.size()), 0);

    // Narrow channels, deeper index: pattern repeats above 7
    drive2(1, 12, 'hF, 0, 0, 0, 12'hF00);
    drive2(1, 15, 'hF, 0, 0, 0, 12'hFFF);
    drive2(1, 3, 'h7, 0, 0, 0, 12'h077);
    drive2(0, 0, 0, 1, 15, 12'h5A3, 0);
    drive2(1, 15, 'hF, 0, 0, 0, 12'h5A3);
    seen = 0;
    while (q2.size() != 0 && seen < 20) begin
      drive2(0, 0, 0, 0, 0, 0, 0);
      seen++;
    end
    check("drain2_empty", 32'(q2.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
